// File: rtl/calc_seq.sv
// Button front-end for the board calculator: synchronise and debounce five buttons,
// turn presses into one-cycle events, and sequence ALU execute / accumulator clear.
`timescale 1ns/1ps
module calc_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnc,
  input  logic       btnl,
  input  logic       btnr,
  input  logic       btnd,
  input  logic       btnu,
  input  logic       zero,
  output logic [3:0] alu_op,
  output logic       acc_we,
  output logic       acc_clr,
  output logic       busy,
  output logic [7:0] exec_count,
  output logic       zero_q
);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, CLEAR} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order of all per-button vectors: {u, d, r, c, l}.
  logic [4:0]       raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       level;
  logic [4:0]       level_q;
  logic [4:0]       press;
  logic [CNT_W-1:0] cnt [5];

  state_t     state;
  state_t     state_d;
  logic [3:0] op_d;

  assign raw = {btnu, btnd, btnr, btnc, btnl};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The counter only runs while the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        cnt[i]   <= '0;
        level[i] <= 1'b0;
      end else if (sync2[i] == level[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        level[i] <= ~level[i];
        cnt[i]   <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      press   <= '0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

  // Events are only looked at in IDLE, so anything arriving while busy is dropped.
  always_comb begin
    state_d = state;
    op_d    = alu_op;
    unique case (state)
      IDLE: begin
        if (press[4])      state_d = CLEAR;
        else if (press[3]) state_d = EXEC;
        else if (press[2]) op_d    = (alu_op == OP_ADD) ? OP_SUB : OP_ADD;
        else if (press[1]) op_d    = OP_OR;
        else if (press[0]) op_d    = OP_AND;
      end
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_op     <= OP_ADD;
      exec_count <= '0;
      zero_q     <= 1'b0;
    end else begin
      state  <= state_d;
      alu_op <= op_d;
      if (state == WRITE) begin
        exec_count <= exec_count + 8'd1;
        zero_q     <= zero;
      end
      if (state == CLEAR) zero_q <= 1'b1;
    end
  end

  assign acc_we  = (state == WRITE);
  assign acc_clr = (state == CLEAR);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a short debounce window; expected values are
// hand-derived from the button timing.
`timescale 1ns/1ps
module tb_calc_seq;

  localparam int DB = 4;
  localparam int L = 0, C = 1, R = 2, D = 3, U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;
  logic       zero = 1'b0;
  logic [3:0] alu_op;
  logic       acc_we;
  logic       acc_clr;
  logic       busy;
  logic [7:0] exec_count;
  logic       zero_q;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int clr_cnt = 0;
  int busy_cnt = 0;
  logic both_seen = 1'b0;
  logic [3:0] exp_q[$];

  calc_seq #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .btnc(btn[C]), .btnl(btn[L]), .btnr(btn[R]), .btnd(btn[D]), .btnu(btn[U]),
    .zero(zero), .alu_op(alu_op), .acc_we(acc_we), .acc_clr(acc_clr),
    .busy(busy), .exec_count(exec_count), .zero_q(zero_q)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (acc_we) we_cnt++;
    if (acc_clr) clr_cnt++;
    if (busy) busy_cnt++;
    if (acc_we && acc_clr) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int idx, input int hold, input int gap);
    btn[idx] = 1'b1;
    wait_cycles(hold);
    btn[idx] = 1'b0;
    wait_cycles(gap);
  endtask

  initial begin
    int w0, c0, b0, first_we;
    @(negedge clk);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(20);
    check("rst_alu_op", alu_op, 4'b0010);
    check("rst_acc_we", acc_we, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_exec_count", exec_count, 0);
    check("rst_zero_q", zero_q, 0);

    // single execute, exact timing
    zero = 1'b1;
    w0 = we_cnt; b0 = busy_cnt; first_we = 0;
    btn[D] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (acc_we && first_we == 0) first_we = k;
      if (k == 10) btn[D] = 1'b0;
    end
    wait_cycles(20);
    check("exec_we_latency", first_we, 9);
    check("exec_we_pulses", we_cnt - w0, 1);
    check("exec_busy_cycles", busy_cnt - b0, 2);
    check("exec_count_1", exec_count, 1);
    check("exec_zero_q", zero_q, 1);

    // op selection sequence
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
    press_btn(R, 8, 8); check("op_r1", alu_op, exp_q.pop_front());
    press_btn(R, 8, 8); check("op_r2", alu_op, exp_q.pop_front());
    press_btn(L, 8, 8); check("op_l", alu_op, exp_q.pop_front());
    press_btn(C, 8, 8); check("op_c", alu_op, exp_q.pop_front());
    press_btn(L, 3, 12); check("op_glitch", alu_op, 4'b0001);

    // execute with zero low so zero_q drops back to 0
    zero = 1'b0;
    press_btn(D, 8, 8);
    check("exec_count_2", exec_count, 2);
    check("exec_zero_q_low", zero_q, 0);

    // btnu and btnd together: clear wins
    w0 = we_cnt; c0 = clr_cnt;
    btn[U] = 1'b1; btn[D] = 1'b1;
    wait_cycles(8);
    btn[U] = 1'b0; btn[D] = 1'b0;
    wait_cycles(12);
    check("clr_pulses", clr_cnt - c0, 1);
    check("clr_no_we", we_cnt - w0, 0);
    check("clr_zero_q", zero_q, 1);
    check("clr_exec_count", exec_count, 2);
    check("clr_alu_op", alu_op, 4'b0001);

    // btnr press landing while busy is dropped
    btn[D] = 1'b1;
    wait_cycles(1);
    btn[R] = 1'b1;
    wait_cycles(8);
    btn[D] = 1'b0; btn[R] = 1'b0;
    wait_cycles(12);
    check("busy_drop_alu_op", alu_op, 4'b0001);
    check("busy_drop_count", exec_count, 3);

    // wrap of exec_count
    for (int n = 0; n < 252; n++) press_btn(D, 8, 8);
    check("count_255", exec_count, 255);
    press_btn(D, 8, 8);
    check("count_wrap", exec_count, 0);
    zero = 1'b1;
    press_btn(D, 8, 8);
    check("count_after_wrap", exec_count, 1);
    check("zero_q_before_rst", zero_q, 1);

    // reset during EXEC, button held through reset
    w0 = we_cnt;
    btn[D] = 1'b1;
    wait_cycles(8);
    check("mid_exec_busy", busy, 1);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("abort_alu_op", alu_op, 4'b0010);
    check("abort_acc_we", acc_we, 0);
    check("abort_acc_clr", acc_clr, 0);
    check("abort_busy", busy, 0);
    check("abort_exec_count", exec_count, 0);
    check("abort_zero_q", zero_q, 0);
    check("abort_no_we", we_cnt - w0, 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 15) btn[D] = 1'b0;
    end
    wait_cycles(10);
    check("held_rst_we", we_cnt - w0, 1);
    check("held_rst_count", exec_count, 1);

    check("we_clr_exclusive", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
